// File: rtl/spi_ram_mem.sv
// spi_ram_mem: 256x8 memory stage behind the SPI slave, returning read data on a held valid/ack handshake.
// Optional macro SPI_RAM_AUTO_INC_EN: post-increment the write/read address on each executed data command.
package shared_pkg;
    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned ADDR_SIZE = 8;
    localparam int unsigned MEM_WIDTH = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } control_e;

    typedef struct packed {
        control_e               control;
        logic [MEM_WIDTH-1:0]   data;
    } rx_data_s;
endpackage

module spi_ram_mem
    import shared_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  rx_data_s             rx_data,
    input  logic                 rx_valid,
    output logic [MEM_WIDTH-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ack,
    output logic                 seq_err
);

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_e;

    tx_state_e              r_state;
    tx_state_e              w_next_state;
    logic [MEM_WIDTH-1:0]   r_mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0]   r_wr_addr;
    logic [ADDR_SIZE-1:0]   r_rd_addr;
    logic                   r_wr_addr_vld;
    logic                   r_rd_addr_vld;
    logic [MEM_WIDTH-1:0]   r_tx_data;
    logic                   r_seq_err;
    logic                   w_wr_addr_ld;
    logic                   w_rd_addr_ld;
    logic                   w_wr_exec;
    logic                   w_rd_accept;
    logic                   w_seq_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command decode; a read may reuse the output slot on the same edge it is acked.
    always_comb begin
        w_next_state = r_state;
        w_wr_addr_ld = 1'b0;
        w_rd_addr_ld = 1'b0;
        w_wr_exec    = 1'b0;
        w_rd_accept  = 1'b0;
        w_seq_err    = 1'b0;

        if (r_state == TX_HOLD && tx_ack) begin
            w_next_state = TX_IDLE;
        end

        if (rx_valid) begin
            unique case (rx_data.control)
                WR_ADDR: w_wr_addr_ld = 1'b1;
                WR_DATA: begin
                    if (r_wr_addr_vld) begin
                        w_wr_exec = 1'b1;
                    end else begin
                        w_seq_err = 1'b1;
                    end
                end
                RD_ADDR: w_rd_addr_ld = 1'b1;
                RD_DATA: begin
                    if (r_rd_addr_vld && (r_state == TX_IDLE || tx_ack)) begin
                        w_rd_accept  = 1'b1;
                        w_next_state = TX_HOLD;
                    end else begin
                        w_seq_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr     <= '0;
            r_rd_addr     <= '0;
            r_wr_addr_vld <= 1'b0;
            r_rd_addr_vld <= 1'b0;
            r_tx_data     <= '0;
            r_seq_err     <= 1'b0;
        end else begin
            r_seq_err <= w_seq_err;
            if (w_wr_addr_ld) begin
                r_wr_addr     <= ADDR_SIZE'(rx_data.data);
                r_wr_addr_vld <= 1'b1;
            end
            if (w_rd_addr_ld) begin
                r_rd_addr     <= ADDR_SIZE'(rx_data.data);
                r_rd_addr_vld <= 1'b1;
            end
            if (w_rd_accept) begin
                r_tx_data <= r_mem[r_rd_addr];
            end
`ifdef SPI_RAM_AUTO_INC_EN
            // Natural 8-bit wrap takes 255 back to 0.
            if (w_wr_exec) begin
                r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
            end
            if (w_rd_accept) begin
                r_rd_addr <= r_rd_addr + ADDR_SIZE'(1);
            end
`endif
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_exec) begin
            r_mem[r_wr_addr] <= rx_data.data;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = (r_state == TX_HOLD);
    assign seq_err  = r_seq_err;

endmodule

// File: tb/tb_spi_ram_mem.sv
// Bench for spi_ram_mem: directed plus random commands scored against a per-cycle behavioural model.
module tb_spi_ram_mem;
    import shared_pkg::*;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    rx_data_s    rx_data;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ack = 1'b0;
    logic        seq_err;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t exp_q[$];

    // Reference state, in terms of the externally visible contract.
    logic [7:0] m_mem [256];
    int         m_wa, m_ra;
    bit         m_wv, m_rv;
    bit         m_valid;
    logic [7:0] m_data;

    spi_ram_mem dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ack   (tx_ack),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_wa = 0; m_ra = 0; m_wv = 0; m_rv = 0; m_valid = 0; m_data = 8'h00;
    endfunction

    function automatic void model_step(input bit vld, input control_e c, input logic [7:0] p, input bit ack);
        exp_t x;
        bit   err = 0;
        bit   busy_after = m_valid && !ack;
        if (vld) begin
            if (c == WR_ADDR) begin
                m_wa = int'(p); m_wv = 1;
            end else if (c == RD_ADDR) begin
                m_ra = int'(p); m_rv = 1;
            end else if (c == WR_DATA) begin
                if (!m_wv) err = 1;
                else begin
                    m_mem[m_wa] = p;
`ifdef SPI_RAM_AUTO_INC_EN
                    m_wa = (m_wa + 1) % 256;
`endif
                end
            end else begin
                if (!m_rv || busy_after) err = 1;
                else begin
                    m_data = m_mem[m_ra];
                    busy_after = 1;
`ifdef SPI_RAM_AUTO_INC_EN
                    m_ra = (m_ra + 1) % 256;
`endif
                end
            end
        end
        m_valid = busy_after;
        x.v = m_valid; x.d = m_data; x.e = err;
        exp_q.push_back(x);
    endfunction

    task automatic step(input bit vld, input control_e c, input logic [7:0] p, input bit ack);
        @(negedge clk); #1;
        rx_valid = vld;
        rx_data  = '{control: c, data: p};
        tx_ack   = ack;
        model_step(vld, c, p, ack);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got v=%b d=%h err=%b, expected v=0 d=00 err=0", tag, tx_valid, tx_data, seq_err);
        end
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk); #1;
        rst = 1'b1;
        rx_valid = 1'b0;
        tx_ack = 1'b0;
        exp_q.delete();
        model_reset();
        #1 check_reset_outputs(tag);
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: one expected response per clock edge, compared half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (tx_valid !== e.v || (e.v && tx_data !== e.d) || seq_err !== e.e) begin
                    n_fail++;
                    $display("FAIL cycle_check t=%0t: got v=%b d=%h err=%b, expected v=%b d=%h err=%b",
                             $time, tx_valid, tx_data, seq_err, e.v, e.d, e.e);
                end
            end
        end
    end

    initial begin
        rx_data = '{control: WR_ADDR, data: 8'h00};
        model_reset();
        #2 check_reset_outputs("reset_state");
        @(negedge clk); #1;
        rst = 1'b0;

        // Write before any address: rejected.
        step(1, WR_DATA, 8'h55, 0);
        step(1, RD_DATA, 8'h00, 0);
        step(0, WR_ADDR, 8'h00, 0);

        for (int i = 0; i < 256; i++) begin
            step(1, WR_ADDR, 8'(i), 0);
            step(1, WR_DATA, 8'($urandom), 0);
        end

        // Round trip, hold, rejected second read, ack/read collision.
        step(1, WR_ADDR, 8'h3C, 0);
        step(1, WR_DATA, 8'hA5, 0);
        step(1, RD_ADDR, 8'h3C, 0);
        step(1, RD_DATA, 8'h00, 0);
        step(0, WR_ADDR, 8'h00, 0);
        step(0, WR_ADDR, 8'h00, 0);
        step(1, RD_DATA, 8'h00, 0);
        step(1, WR_ADDR, 8'h3C, 0);
        step(1, WR_DATA, 8'h5A, 0);
        step(1, RD_ADDR, 8'h3C, 0);
        step(1, RD_DATA, 8'h00, 1);
        step(0, WR_ADDR, 8'h00, 1);
        step(0, WR_ADDR, 8'h00, 1);

        // Address 0xFF stimulus (wraps when auto-increment is built in).
        step(1, WR_ADDR, 8'hFF, 0);
        step(1, WR_DATA, 8'h11, 0);
        step(1, WR_DATA, 8'h22, 0);
        step(1, RD_ADDR, 8'hFF, 0);
        step(1, RD_DATA, 8'h00, 0);
        step(0, WR_ADDR, 8'h00, 0);
        step(1, RD_DATA, 8'h00, 1);
        step(0, WR_ADDR, 8'h00, 1);

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, control_e'($urandom_range(0, 3)), 8'($urandom),
                 $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of a held read.
        step(1, RD_ADDR, 8'h10, 0);
        step(1, RD_DATA, 8'h00, 0);
        step(0, WR_ADDR, 8'h00, 0);
        async_reset("reset_mid_hold");
        step(1, RD_DATA, 8'h00, 0);
        step(1, WR_DATA, 8'h55, 0);
        step(1, RD_ADDR, 8'h00, 0);
        step(1, RD_DATA, 8'h00, 0);
        step(0, WR_ADDR, 8'h00, 1);
        step(0, WR_ADDR, 8'h00, 0);
        @(negedge clk);
        #2;

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
